// File: rtl/yuv2rgb_top.sv
// yuv2rgb_top: frame-level BT.601 YUV->RGB converter.
// Each pixel pair takes 8 cycles: read Y/U/V words, convert, write three packed RGB words.
module yuv2rgb_top #(
    parameter int unsigned W               = 320,
    parameter int unsigned H               = 240,
    parameter int unsigned DW              = 16,
    parameter int unsigned AW              = 18,
    parameter int unsigned Y_BASE          = 0,
    parameter int unsigned U_BASE          = 38400,
    parameter int unsigned V_BASE          = 76800,
    parameter int unsigned WRITE_ADDR_BASE = 115200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          wr_enable
);

    localparam int unsigned   PAIRS  = W * H / 2;
    localparam logic [AW-1:0] LAST_K = AW'(PAIRS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RY,
        S_RU,
        S_RV,
        S_CAP,
        S_CALC,
        S_W0,
        S_W1,
        S_W2,
        S_DONE
    } state_t;

    state_t        state, state_next;
    logic [AW-1:0] k, k_next;
    logic [AW-1:0] raddr_next, waddr_next;
    logic [DW-1:0] wdata_next;
    logic          wr_enable_next, done_next;

    logic [DW-1:0] y_word, u_word, v_word;
    logic [7:0]    b0_q;
    logic [23:0]   rgb1_q;
    logic [23:0]   rgb0_c, rgb1_c;

    // Saturate a signed intermediate to an 8-bit channel value.
    function automatic logic [7:0] clip8(input logic signed [31:0] x);
        if (x < 32'sd0) begin
            return 8'd0;
        end else if (x > 32'sd255) begin
            return 8'd255;
        end else begin
            return x[7:0];
        end
    endfunction

    // BT.601 fixed-point (16 fractional bits) conversion of one pixel to {R,G,B}.
    function automatic logic [23:0] pix2rgb(input logic [7:0] y8,
                                            input logic [7:0] u8,
                                            input logic [7:0] v8);
        logic signed [31:0] ys, us, vs, r, g, b;
        ys = $signed(32'(y8)) - 32'sd16;
        us = $signed(32'(u8)) - 32'sd128;
        vs = $signed(32'(v8)) - 32'sd128;
        r  = (32'sd76284 * ys + 32'sd104595 * vs) >>> 16;
        g  = (32'sd76284 * ys - 32'sd25624 * us - 32'sd53281 * vs) >>> 16;
        b  = (32'sd76284 * ys + 32'sd132251 * us) >>> 16;
        return {clip8(r), clip8(g), clip8(b)};
    endfunction

    // Conversion of the even (high byte) and odd (low byte) pixel of the current pair.
    assign rgb0_c = pix2rgb(y_word[15:8], u_word[15:8], v_word[15:8]);
    assign rgb1_c = pix2rgb(y_word[7:0],  u_word[7:0],  v_word[7:0]);

    // State, pair index and registered SRAM-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            k         <= '0;
            raddr     <= '0;
            waddr     <= '0;
            wdata     <= '0;
            wr_enable <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            k         <= k_next;
            raddr     <= raddr_next;
            waddr     <= waddr_next;
            wdata     <= wdata_next;
            wr_enable <= wr_enable_next;
            done      <= done_next;
        end
    end

    // Capture returning sample words; keep the bytes still needed after W0.
    always_ff @(posedge clk) begin
        if (state == S_RU) begin
            y_word <= rdata;
        end
        if (state == S_RV) begin
            u_word <= rdata;
        end
        if (state == S_CAP) begin
            v_word <= rdata;
        end
        if (state == S_CALC) begin
            b0_q   <= rgb0_c[7:0];
            rgb1_q <= rgb1_c;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_next     = state;
        k_next         = k;
        raddr_next     = raddr;
        waddr_next     = waddr;
        wdata_next     = wdata;
        wr_enable_next = 1'b0;
        done_next      = 1'b0;
        case (state)
            S_IDLE: begin
                k_next = '0;
                if (start) begin
                    state_next = S_RY;
                    raddr_next = AW'(Y_BASE);
                end
            end
            S_RY: begin
                state_next = S_RU;
                raddr_next = AW'(U_BASE) + k;
            end
            S_RU: begin
                state_next = S_RV;
                raddr_next = AW'(V_BASE) + k;
            end
            S_RV: begin
                state_next = S_CAP;
            end
            S_CAP: begin
                state_next = S_CALC;
            end
            S_CALC: begin
                state_next     = S_W0;
                wr_enable_next = 1'b1;
                waddr_next     = AW'(WRITE_ADDR_BASE) + k + (k << 1);
                wdata_next     = DW'(rgb0_c[23:8]);
            end
            S_W0: begin
                state_next     = S_W1;
                wr_enable_next = 1'b1;
                waddr_next     = waddr + AW'(1);
                wdata_next     = DW'({b0_q, rgb1_q[23:16]});
            end
            S_W1: begin
                state_next     = S_W2;
                wr_enable_next = 1'b1;
                waddr_next     = waddr + AW'(1);
                wdata_next     = DW'(rgb1_q[15:0]);
            end
            S_W2: begin
                if (k == LAST_K) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    state_next = S_RY;
                    k_next     = k + AW'(1);
                    raddr_next = AW'(Y_BASE) + k + AW'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
